// File: rtl/irrigacao_multizona_if.sv
// Field-side signal bundle of the multizone irrigation controller:
// tank and per-zone sensors in, valve/status drivers out.
interface irrigacao_multizona_if #(
  parameter int N_ZONAS = 4
);
  localparam int ZW = (N_ZONAS > 1) ? $clog2(N_ZONAS) : 1;

  logic               Alta;
  logic               Media;
  logic               Baixa;
  logic [N_ZONAS-1:0] Solo;
  logic [N_ZONAS-1:0] Umidade;
  logic [N_ZONAS-1:0] Temperatura;
  logic               Erro;
  logic               Alarme;
  logic               Ve;
  logic [N_ZONAS-1:0] Aspersao;
  logic [N_ZONAS-1:0] Gotejamento;
  logic [ZW-1:0]      Zona_ativa;
  logic               Ocupado;

  modport master (
    output Alta, Media, Baixa, Solo, Umidade, Temperatura,
    input  Erro, Alarme, Ve, Aspersao, Gotejamento, Zona_ativa, Ocupado
  );

  modport slave (
    input  Alta, Media, Baixa, Solo, Umidade, Temperatura,
    output Erro, Alarme, Ve, Aspersao, Gotejamento, Zona_ativa, Ocupado
  );
endinterface

// File: rtl/irrigacao_multizona.sv
// Tank monitor (filtered sensor fault, empty alarm, fill valve with hysteresis)
// plus a round-robin scheduler that serves one irrigation zone at a time on a shared pump.
//
// state  | meaning
// OCIOSO | idle, looking for the next dry zone after the pointer
// IRRIGA | one zone being watered, run counter advancing
// PAUSA  | pump rest gap between activations
// FALHA  | tank fault or empty tank, all valves closed
module irrigacao_multizona #(
  parameter int N_ZONAS  = 4,
  parameter int T_MIN    = 8,
  parameter int T_MAX    = 64,
  parameter int T_PAUSA  = 4,
  parameter int ERR_FILT = 3
) (
  input logic                  clk,
  input logic                  reset,
  irrigacao_multizona_if.slave bus
);
  localparam int ZW = (N_ZONAS > 1) ? $clog2(N_ZONAS) : 1;
  localparam int CW = $clog2(T_MAX + 1);
  localparam int FW = $clog2(ERR_FILT + 1);
  localparam int PW = (T_PAUSA > 1) ? $clog2(T_PAUSA) : 1;

  typedef enum logic [1:0] {OCIOSO, IRRIGA, PAUSA, FALHA} estado_t;

  estado_t            est_q, est_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      tmr_q, tmr_d;
  logic [ZW-1:0]      ptr_q, ptr_d;
  logic [ZW-1:0]      zona_q, zona_d;
  logic               asp_q, asp_d;
  logic [FW-1:0]      filt_q, filt_d;
  logic               erro_q, erro_d;
  logic               alarme_q, alarme_d;
  logic               ve_q, ve_d;
  logic               ocup_q;
  logic [N_ZONAS-1:0] aspersao_q, gotejamento_q;
  logic               invalido, ok, valv_d, achou;
  logic [ZW-1:0]      prox;
  logic [N_ZONAS-1:0] sel_hot;

  assign invalido = (bus.Alta & ~bus.Media) | (bus.Media & ~bus.Baixa) | (bus.Alta & ~bus.Baixa);

  // Erro only flips after the opposite pattern has held ERR_FILT samples in a row.
  always_comb begin
    erro_d = erro_q;
    filt_d = '0;
    if (invalido != erro_q) begin
      if (filt_q == FW'(ERR_FILT - 1)) erro_d = invalido;
      else                             filt_d = filt_q + 1'b1;
    end
  end

  assign alarme_d = ~bus.Baixa & ~erro_d;
  assign ok       = ~erro_d & ~alarme_d;

  always_comb begin
    ve_d = ve_q;
    if (erro_d || bus.Alta)             ve_d = 1'b0;
    else if (!bus.Media && !invalido)   ve_d = 1'b1;
  end

  always_comb begin
    achou = 1'b0;
    prox  = ptr_q;
    for (int k = 1; k <= N_ZONAS; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % N_ZONAS;
      if (!achou && bus.Solo[idx]) begin
        achou = 1'b1;
        prox  = ZW'(idx);
      end
    end
  end

  always_comb begin
    sel_hot         = '0;
    sel_hot[zona_q] = 1'b1;
  end

  always_comb begin
    est_d  = est_q;
    cnt_d  = cnt_q;
    tmr_d  = tmr_q;
    ptr_d  = ptr_q;
    zona_d = zona_q;
    asp_d  = asp_q;
    valv_d = 1'b0;
    unique case (est_q)
      OCIOSO: begin
        if (!ok) est_d = FALHA;
        else if (achou) begin
          est_d  = IRRIGA;
          ptr_d  = prox;
          zona_d = prox;
          asp_d  = ~bus.Umidade[prox] & ~bus.Temperatura[prox];
          cnt_d  = CW'(1);
        end
      end
      IRRIGA: begin
        if (!ok) est_d = FALHA;
        else begin
          valv_d = 1'b1;
          if ((cnt_q >= CW'(T_MIN) && !bus.Solo[zona_q]) || cnt_q == CW'(T_MAX)) begin
            est_d = PAUSA;
            tmr_d = PW'(T_PAUSA - 1);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PAUSA: begin
        if (!ok)              est_d = FALHA;
        else if (tmr_q == '0) est_d = OCIOSO;
        else                  tmr_d = tmr_q - 1'b1;
      end
      FALHA: begin
        if (ok) begin
          est_d = PAUSA;
          tmr_d = PW'(T_PAUSA - 1);
        end
      end
      default: est_d = OCIOSO;
    endcase
  end

  // Valves follow the state of the previous cycle, but a fault closes them on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      est_q         <= OCIOSO;
      cnt_q         <= '0;
      tmr_q         <= '0;
      ptr_q         <= ZW'(N_ZONAS - 1);
      zona_q        <= '0;
      asp_q         <= 1'b0;
      filt_q        <= '0;
      erro_q        <= 1'b0;
      alarme_q      <= 1'b0;
      ve_q          <= 1'b0;
      ocup_q        <= 1'b0;
      aspersao_q    <= '0;
      gotejamento_q <= '0;
    end else begin
      est_q         <= est_d;
      cnt_q         <= cnt_d;
      tmr_q         <= tmr_d;
      ptr_q         <= ptr_d;
      zona_q        <= zona_d;
      asp_q         <= asp_d;
      filt_q        <= filt_d;
      erro_q        <= erro_d;
      alarme_q      <= alarme_d;
      ve_q          <= ve_d;
      ocup_q        <= valv_d;
      aspersao_q    <= (valv_d && asp_q)  ? sel_hot : '0;
      gotejamento_q <= (valv_d && !asp_q) ? sel_hot : '0;
    end
  end

  assign bus.Erro        = erro_q;
  assign bus.Alarme      = alarme_q;
  assign bus.Ve          = ve_q;
  assign bus.Ocupado     = ocup_q;
  assign bus.Zona_ativa  = zona_q;
  assign bus.Aspersao    = aspersao_q;
  assign bus.Gotejamento = gotejamento_q;
endmodule

// File: tb/tb_irrigacao_multizona.sv
// Scoreboard bench for irrigacao_multizona: directed scenarios and random field
// stimulus, each cycle predicted by a rule-level model and checked by a monitor.
module tb_irrigacao_multizona;
  localparam int N    = 4;
  localparam int TMIN = 8;
  localparam int TMAX = 64;
  localparam int TP   = 4;
  localparam int EF   = 3;
  localparam int ZW   = 2;

  localparam int IDLE  = 0;
  localparam int RUN   = 1;
  localparam int REST  = 2;
  localparam int FAULT = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  irrigacao_multizona_if #(.N_ZONAS(N)) bus ();

  irrigacao_multizona #(
    .N_ZONAS(N), .T_MIN(TMIN), .T_MAX(TMAX), .T_PAUSA(TP), .ERR_FILT(EF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    bit         erro;
    bit         alarme;
    bit         ve;
    bit         ocup;
    int         zona;
    bit [N-1:0] asp;
    bit [N-1:0] got;
    int         seg;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   seg     = 0;

  // model of the controller, expressed as the rules it must obey
  bit m_erro, m_alarme, m_ve, m_sprink;
  int m_streak, m_phase, m_cnt, m_rest, m_ptr, m_zone;

  task automatic model_step(input bit a, input bit m, input bit b,
                            input bit [N-1:0] solo, input bit [N-1:0] umid,
                            input bit [N-1:0] temp, input bit rst);
    exp_t e;
    bit bad, ok, valve;
    valve = 1'b0;
    if (rst) begin
      m_erro = 0; m_alarme = 0; m_ve = 0; m_sprink = 0;
      m_streak = 0; m_phase = IDLE; m_cnt = 0; m_rest = 0;
      m_ptr = N - 1; m_zone = 0;
    end else begin
      bad = (a && !m) || (m && !b) || (a && !b);
      if (bad != m_erro) begin
        m_streak++;
        if (m_streak >= EF) begin
          m_erro   = bad;
          m_streak = 0;
        end
      end else m_streak = 0;
      m_alarme = !b && !m_erro;
      if (m_erro || a)    m_ve = 0;
      else if (!m && !bad) m_ve = 1;
      ok    = !m_erro && !m_alarme;
      valve = (m_phase == RUN) && ok;
      case (m_phase)
        IDLE: begin
          if (!ok) m_phase = FAULT;
          else if (solo != '0) begin
            for (int k = 1; k <= N; k++) begin
              int z;
              z = (m_ptr + k) % N;
              if (solo[z]) begin
                m_zone = z;
                break;
              end
            end
            m_ptr    = m_zone;
            m_sprink = !umid[m_zone] && !temp[m_zone];
            m_cnt    = 1;
            m_phase  = RUN;
          end
        end
        RUN: begin
          if (!ok) m_phase = FAULT;
          else if ((m_cnt >= TMIN && !solo[m_zone]) || m_cnt == TMAX) begin
            m_phase = REST;
            m_rest  = 0;
          end else m_cnt++;
        end
        REST: begin
          if (!ok) m_phase = FAULT;
          else begin
            m_rest++;
            if (m_rest >= TP) m_phase = IDLE;
          end
        end
        default: begin
          if (ok) begin
            m_phase = REST;
            m_rest  = 0;
          end
        end
      endcase
    end
    e.erro   = m_erro;
    e.alarme = m_alarme;
    e.ve     = m_ve;
    e.ocup   = valve;
    e.zona   = m_zone;
    e.asp    = (valve && m_sprink)  ? (N'(1) << m_zone) : '0;
    e.got    = (valve && !m_sprink) ? (N'(1) << m_zone) : '0;
    e.seg    = seg;
    sb.push_back(e);
  endtask

  task automatic cyc(input bit a, input bit m, input bit b, input bit [N-1:0] solo,
                     input bit [N-1:0] umid, input bit [N-1:0] temp, input bit rst);
    @(negedge clk);
    bus.Alta        = a;
    bus.Media       = m;
    bus.Baixa       = b;
    bus.Solo        = solo;
    bus.Umidade     = umid;
    bus.Temperatura = temp;
    reset           = rst;
    model_step(a, m, b, solo, umid, temp, rst);
  endtask

  task automatic run(input int n, input bit a, input bit m, input bit b,
                     input bit [N-1:0] solo, input bit [N-1:0] umid, input bit [N-1:0] temp);
    for (int i = 0; i < n; i++) cyc(a, m, b, solo, umid, temp, 1'b0);
  endtask

  task automatic do_reset(input bit [N-1:0] solo);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b1, solo, '0, '0, 1'b1);
  endtask

  // monitor: one comparison per DUT output cycle
  always begin : monitor
    exp_t e;
    bit   bad;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      bad = (bus.Erro !== e.erro) || (bus.Alarme !== e.alarme) || (bus.Ve !== e.ve) ||
            (bus.Ocupado !== e.ocup) || (bus.Aspersao !== e.asp) || (bus.Gotejamento !== e.got) ||
            (e.ocup && bus.Zona_ativa !== ZW'(e.zona));
      if (bad) begin
        n_fail++;
        if (n_fail <= 30)
          $display("FAIL seg%0d t=%0t: got Erro=%b Alarme=%b Ve=%b Ocupado=%b Zona=%0d Asp=%b Got=%b, expected Erro=%b Alarme=%b Ve=%b Ocupado=%b Zona=%0d Asp=%b Got=%b",
                   e.seg, $time, bus.Erro, bus.Alarme, bus.Ve, bus.Ocupado, bus.Zona_ativa,
                   bus.Aspersao, bus.Gotejamento, e.erro, e.alarme, e.ve, e.ocup, e.zona, e.asp, e.got);
      end
    end
  end

  initial begin
    bit a, m, b;
    bit [N-1:0] solo, umid, temp;
    bus.Alta = 0; bus.Media = 1; bus.Baixa = 1;
    bus.Solo = '1; bus.Umidade = '0; bus.Temperatura = '0;

    // reset with every zone dry; zone 0 then runs the full T_MAX
    seg = 1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, '1, '0, '0, 1'b1);
    run(80, 1'b0, 1'b1, 1'b1, '1, '0, '0);

    // round-robin over zones 1 and 3
    seg = 2; do_reset(4'b1010);
    run(220, 1'b0, 1'b1, 1'b1, 4'b1010, '0, '0);

    // soil wets early: valve held only T_MIN
    seg = 3; do_reset('0);
    run(4, 1'b0, 1'b1, 1'b1, 4'b0100, '0, 4'b1111);
    run(20, 1'b0, 1'b1, 1'b1, '0, '0, 4'b1111);

    // sensor fault filter: 2 invalid cycles ignored, 3 trip Erro
    seg = 4; do_reset('0);
    run(10, 1'b0, 1'b1, 1'b1, 4'b0001, '0, '0);
    run(2, 1'b1, 1'b0, 1'b1, 4'b0001, '0, '0);
    run(5, 1'b0, 1'b1, 1'b1, 4'b0001, '0, '0);
    run(5, 1'b1, 1'b0, 1'b1, 4'b0001, '0, '0);
    run(25, 1'b0, 1'b0, 1'b1, 4'b0001, '0, '0);

    // empty tank mid-run, then refill
    seg = 5; do_reset('0);
    run(8, 1'b0, 1'b1, 1'b1, 4'b0010, '0, '0);
    run(3, 1'b0, 1'b0, 1'b0, 4'b0010, '0, '0);
    run(25, 1'b0, 1'b0, 1'b1, 4'b0010, '0, '0);

    // mode frozen for an activation despite temperature change
    seg = 6; do_reset('0);
    run(6, 1'b0, 1'b1, 1'b1, 4'b0001, '0, '0);
    run(20, 1'b0, 1'b1, 1'b1, 4'b0001, '0, 4'b1111);
    run(60, 1'b0, 1'b1, 1'b1, 4'b1000, '0, 4'b1111);

    // random field conditions
    seg = 7;
    a = 0; m = 1; b = 1; solo = 4'b0101; umid = '0; temp = '0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        if ($urandom_range(0, 4) == 0) {a, m, b} = 3'($urandom_range(0, 7));
        else begin
          case ($urandom_range(0, 3))
            0:       {a, m, b} = 3'b000;
            1:       {a, m, b} = 3'b001;
            2:       {a, m, b} = 3'b011;
            default: {a, m, b} = 3'b111;
          endcase
        end
      end
      if ($urandom_range(0, 15) == 0) solo = N'($urandom);
      if ($urandom_range(0, 15) == 0) umid = N'($urandom);
      if ($urandom_range(0, 15) == 0) temp = N'($urandom);
      cyc(a, m, b, solo, umid, temp, ($urandom_range(0, 499) == 0));
    end

    repeat (3) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected cycles left unchecked, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
